// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encoding,
// 7-segment glyph constants and elaboration-time sizing helpers.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  function automatic bit digits_fit(input int width, input int digits);
    longint unsigned max_bin;
    longint unsigned pow10;
    max_bin = (longint'(1) << width) - 1;
    pow10   = 1;
    for (int i = 0; i < digits; i++) begin
      pow10 = pow10 * 10;
    end
    return (pow10 > max_bin);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: digits of 5 or more get +3 before the shift
// so that the doubled value carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  assign d_out = (d_in >= 4'd5) ? (d_in + 4'd3) : d_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one operand bit per clock,
// valid/ready on both sides. Define BCD_SEVSEG_EN to add registered out_seg.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd
`ifdef BCD_SEVSEG_EN
  ,
  output logic [7*DIGITS-1:0]   out_seg
`endif
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1) begin : g_width_err
    $error("bin_to_bcd_seq: WIDTH must be at least 1");
  end
  if (!digits_fit(WIDTH, DIGITS)) begin : g_digits_err
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   out_bcd_q, out_bcd_d;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [4*DIGITS-1:0]   bcd_shift;
  logic                  unused_adj_msb;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .d_in  (bcd_q[4*k +: 4]),
      .d_out (bcd_adj[4*k +: 4])
    );
  end

  // The top digit never reaches 8 because of the width check, so its MSB is dropped.
  assign bcd_shift      = {bcd_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
  assign unused_adj_msb = bcd_adj[4*DIGITS-1];

`ifdef BCD_SEVSEG_EN
  logic [7*DIGITS-1:0] seg_q, seg_d;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Walk from the most significant digit down, blanking zeros until the first nonzero.
  function automatic logic [7*DIGITS-1:0] seg_decode(input logic [4*DIGITS-1:0] bcd);
    logic [7*DIGITS-1:0] segs;
    logic                leading;
    segs    = '0;
    leading = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if ((bcd[4*k +: 4] != 4'd0) || (k == 0)) begin
        leading = 1'b0;
      end
      segs[7*k +: 7] = leading ? SEG_BLANK : digit_to_seg(bcd[4*k +: 4]);
    end
    return segs;
  endfunction

  assign out_seg = seg_q;
`endif

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    out_bcd_d = out_bcd_q;
`ifdef BCD_SEVSEG_EN
    seg_d     = seg_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d   = in_bin;
          bcd_d   = '0;
          cnt_d   = CNT_LAST;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = bin_q << 1;
        if (cnt_q == '0) begin
          state_d   = ST_DONE;
          out_bcd_d = bcd_shift;
`ifdef BCD_SEVSEG_EN
          seg_d     = seg_decode(bcd_shift);
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      out_bcd_q <= '0;
`ifdef BCD_SEVSEG_EN
      seg_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      out_bcd_q <= out_bcd_d;
`ifdef BCD_SEVSEG_EN
      seg_q     <= seg_d;
`endif
    end
  end

  assign out_bcd = out_bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (8-bit/3-digit and 16-bit/5-digit).
module tb_bin_to_bcd_seq;

  localparam int W = 8;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
`ifdef BCD_SEVSEG_EN
  logic [20:0] out_seg;
`endif

  logic        b_in_valid;
  logic        b_in_ready;
  logic [15:0] b_in_bin;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [19:0] b_out_bcd;
`ifdef BCD_SEVSEG_EN
  logic [34:0] b_out_seg;
`endif

  int vectors;
  int miscompares;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd)
`ifdef BCD_SEVSEG_EN
    ,
    .out_seg   (out_seg)
`endif
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_bin    (b_in_bin),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_bcd   (b_out_bcd)
`ifdef BCD_SEVSEG_EN
    ,
    .out_seg   (b_out_seg)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] ref_bcd(input int value);
    logic [31:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge with the converter idle; returns at the negedge after it is idle again.
  task automatic convert(input logic [7:0] value, input string tag);
    int   n;
    logic busy_ok;
    in_valid  = 1'b1;
    in_bin    = value;
    out_ready = 1'b1;
    n         = 0;
    busy_ok   = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid && in_ready) busy_ok = 1'b0;
    end while (!out_valid && n < 40);
    check({tag, " latency"}, n, W + 1);
    check({tag, " busy"}, busy_ok, 1);
    check({tag, " bcd"}, out_bcd, ref_bcd(value));
    check({tag, " ready_done"}, in_ready, 0);
    @(negedge clk);
    n++;
    check({tag, " period"}, n, W + 2);
    check({tag, " ready_idle"}, in_ready, 1);
  endtask

  initial begin
    int   n;
    logic seen;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_bin      = '0;
    out_ready   = 1'b0;
    b_in_valid  = 1'b0;
    b_in_bin    = '0;
    b_out_ready = 1'b0;

    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_bcd", out_bcd, 0);
`ifdef BCD_SEVSEG_EN
    check("reset out_seg", out_seg, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-scale operand
    convert(8'd255, "t1_255");
    in_valid = 1'b0;
    check("t1 hex", out_bcd, 32'h255);
    check("t1 idle out_valid", out_valid, 0);
    @(negedge clk);
    check("t1 retained", out_bcd, 32'h255);

    // Back-pressure: result must hold while out_ready is low
    in_valid  = 1'b1;
    in_bin    = 8'd9;
    out_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        in_bin   = 8'hAA;
      end
    end while (!out_valid && n < 40);
    check("t3 latency", n, W + 1);
    for (int i = 0; i < 5; i++) begin
      check("t3 hold out_valid", out_valid, 1);
      check("t3 hold bcd", out_bcd, 32'h009);
      check("t3 hold in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3 release in_ready", in_ready, 1);
    check("t3 release out_valid", out_valid, 0);
    check("t3 release bcd kept", out_bcd, 32'h009);

    // Reset in the fourth SHIFT cycle discards the operand
    in_valid = 1'b1;
    in_bin   = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t4 reset in_ready", in_ready, 1);
    check("t4 reset out_valid", out_valid, 0);
    check("t4 reset out_bcd", out_bcd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("t4 no stale result", seen, 0);
    convert(8'd37, "t4_37");
    in_valid = 1'b0;
    check("t4 hex", out_bcd, 32'h037);

    // Zero operand
    convert(8'd0, "t_zero");
    in_valid = 1'b0;
    check("zero hex", out_bcd, 32'h000);

`ifdef BCD_SEVSEG_EN
    convert(8'd57, "t6_57");
    in_valid = 1'b0;
    check("t6 seg 57", out_seg, {7'h00, 7'h6D, 7'h07});
    convert(8'd0, "t6_0");
    in_valid = 1'b0;
    check("t6 seg 0", out_seg, {7'h00, 7'h00, 7'h3F});
    convert(8'd100, "t6_100");
    in_valid = 1'b0;
    check("t6 seg 100", out_seg, {7'h06, 7'h3F, 7'h3F});
`endif

    // Back-to-back sweep with in_valid held high
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), "t2_sweep");
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Wide instance, full scale
    b_in_valid  = 1'b1;
    b_in_bin    = 16'hFFFF;
    b_out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) b_in_valid = 1'b0;
    end while (!b_out_valid && n < 60);
    check("t5 latency", n, 17);
    check("t5 bcd", b_out_bcd, 32'h65535);
    @(negedge clk);
    check("t5 ready after", b_in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
